// File: rtl/lcd_hd44780_driver_if.sv
// Bus bundle between the CPU-side store port and the HD44780 driver.
// Carries the write strobe/word in and the LCD pins plus status out.
interface lcd_hd44780_driver_if;
  logic        i_wr;
  logic [31:0] i_word;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic        o_busy;
  logic        o_full;
  logic        o_overflow;
  logic        o_init_done;

  modport master (
    output i_wr, i_word,
    input  o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en,
    input  o_lcd_on, o_busy, o_full, o_overflow, o_init_done
  );

  modport slave (
    input  i_wr, i_word,
    output o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en,
    output o_lcd_on, o_busy, o_full, o_overflow, o_init_done
  );
endinterface

// File: rtl/lcd_hd44780_driver.sv
// HD44780 write-only driver: power-up delay, fixed init sequence,
// 4-entry byte FIFO and SETUP/PULSE/HOLD/WAIT bus timing.
module lcd_hd44780_driver #(
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 16,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_LONG  = 80000,
  parameter int unsigned T_PWRUP = 750000
) (
  input logic i_clk,
  input logic i_reset,
  lcd_hd44780_driver_if.slave bus
);

  localparam logic [19:0] C_SETUP = 20'(T_SETUP);
  localparam logic [19:0] C_EN    = 20'(T_EN);
  localparam logic [19:0] C_HOLD  = 20'(T_HOLD);
  localparam logic [19:0] C_EXEC  = 20'(T_EXEC);
  localparam logic [19:0] C_LONG  = 20'(T_LONG);
  localparam logic [19:0] C_PWRUP = 20'(T_PWRUP);

  typedef enum logic [2:0] {
    S_PWRUP, S_INIT, S_IDLE, S_SETUP,
    S_PULSE, S_HOLD, S_WAIT
  } state_t;

  state_t      state, state_n;
  logic [19:0] cnt, cnt_n;
  logic [1:0]  step, step_n;
  logic        init_done, init_done_n;
  logic        en, en_n, rs, rs_n;
  logic [7:0]  data, data_n;
  logic [7:0]  init_cmd;
  logic        done, long_wait;

  logic [8:0]  fifo [4];
  logic [1:0]  wp, rp;
  logic [2:0]  count;
  logic        push, pop, on, ovf;
  logic        unused_bits;

  assign done      = (cnt <= 20'd1);
  assign long_wait = !rs && (data == 8'h01 || data == 8'h02 ||
                             data == 8'h03);
  assign push      = bus.i_wr && (count != 3'd4);
  assign pop       = (state == S_IDLE) && (state_n == S_SETUP);
  assign unused_bits = ^{bus.i_word[30:9]};

  // Fixed init command for the current step.
  always_comb begin
    init_cmd = 8'h06;
    case (step)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  end

  // State register plus registered pin outputs; reset drops EN at once.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_PWRUP;
      cnt       <= C_PWRUP;
      step      <= 2'd0;
      init_done <= 1'b0;
      en        <= 1'b0;
      rs        <= 1'b0;
      data      <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      step      <= step_n;
      init_done <= init_done_n;
      en        <= en_n;
      rs        <= rs_n;
      data      <= data_n;
    end
  end

  // Next-state decode; every timed state exits when the counter hits 1.
  always_comb begin
    state_n = state;
    unique case (state)
      S_PWRUP: if (done) state_n = S_INIT;
      S_INIT:  state_n = S_SETUP;
      S_IDLE:  if (count != 3'd0) state_n = S_SETUP;
      S_SETUP: if (done) state_n = S_PULSE;
      S_PULSE: if (done) state_n = S_HOLD;
      S_HOLD:  if (done) state_n = S_WAIT;
      S_WAIT:
        if (done)
          state_n = (init_done || step == 2'd3) ? S_IDLE : S_INIT;
      default: state_n = S_PWRUP;
    endcase
  end

  // Output/next-value logic: counter reload, EN, byte latch, init step.
  always_comb begin
    cnt_n       = (cnt != 20'd0) ? cnt - 20'd1 : 20'd0;
    en_n        = (state_n == S_PULSE);
    rs_n        = rs;
    data_n      = data;
    step_n      = step;
    init_done_n = init_done;
    if (state_n != state) begin
      unique case (state_n)
        S_SETUP: cnt_n = C_SETUP;
        S_PULSE: cnt_n = C_EN;
        S_HOLD:  cnt_n = C_HOLD;
        S_WAIT:  cnt_n = long_wait ? C_LONG : C_EXEC;
        default: cnt_n = 20'd0;
      endcase
    end
    if (state == S_INIT) begin
      rs_n   = 1'b0;
      data_n = init_cmd;
    end else if (pop) begin
      {rs_n, data_n} = fifo[rp];
    end
    if (state == S_WAIT && done && !init_done) begin
      if (step == 2'd3) init_done_n = 1'b1;
      else step_n = step + 2'd1;
    end
  end

  // FIFO storage; a full FIFO refuses the write even if a pop coincides.
  always_ff @(posedge i_clk) begin
    if (push) fifo[wp] <= {bus.i_word[8], bus.i_word[7:0]};
  end

  // FIFO pointers, power latch and sticky overflow flag.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      count <= 3'd0;
      on    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (bus.i_wr) on <= bus.i_word[31];
      if (bus.i_wr && count == 3'd4) ovf <= 1'b1;
      if (push) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end

  assign bus.o_lcd_data  = data;
  assign bus.o_lcd_rs    = rs;
  assign bus.o_lcd_rw    = 1'b0;
  assign bus.o_lcd_en    = en;
  assign bus.o_lcd_on    = on;
  assign bus.o_busy      = (state != S_IDLE) || (count != 3'd0);
  assign bus.o_full      = (count == 3'd4);
  assign bus.o_overflow  = ovf;
  assign bus.o_init_done = init_done;

endmodule

// File: tb/tb_lcd_hd44780_driver.sv
// Directed bench for lcd_hd44780_driver with shortened timing.
// Tracks EN pulses at negedge and checks bytes, widths and spacing.
module tb_lcd_hd44780_driver;

  localparam int TS = 2, TE = 3, TH = 2, TX = 10, TL = 40, TP = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  lcd_hd44780_driver_if bus();

  lcd_hd44780_driver #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH),
    .T_EXEC(TX), .T_LONG(TL), .T_PWRUP(TP)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic       en_q = 1'b0;
  int         rise_start = 0;
  int         rise_cyc[$];
  logic [8:0] rise_val[$];
  int         width[$];

  always @(negedge clk) begin
    if (bus.o_lcd_en && !en_q) begin
      rise_cyc.push_back(cyc);
      rise_val.push_back({bus.o_lcd_rs, bus.o_lcd_data});
      rise_start = cyc;
    end
    if (!bus.o_lcd_en && en_q) width.push_back(cyc - rise_start);
    en_q = bus.o_lcd_en;
  end

  typedef struct {
    logic [31:0] word;
    logic        on;
    logic [8:0]  val;
    int          wt;
  } vec_t;

  vec_t tv[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] w);
    bus.i_wr   = 1'b1;
    bus.i_word = w;
    tick();
    bus.i_wr   = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k;
    k = 0;
    while (width.size() < n && k < budget) begin
      tick();
      k++;
    end
    check("pulse_timeout", width.size() >= n, 1);
  endtask

  task automatic wait_idle(output int at);
    int k;
    k = 0;
    while (bus.o_busy && k < 500) begin
      tick();
      k++;
    end
    at = cyc;
    check("idle_timeout", bus.o_busy, 0);
  endtask

  initial begin
    int r, w, at, idx, base, k;
    logic [7:0] init_seq[4];
    int init_gap[3];

    init_seq[0] = 8'h38; init_seq[1] = 8'h0C;
    init_seq[2] = 8'h01; init_seq[3] = 8'h06;
    init_gap[0] = TS + TE + TH + TX + 1;
    init_gap[1] = TS + TE + TH + TL + 1;
    init_gap[2] = TS + TE + TH + TX + 1;
    init_gap[0] = TS + TE + TH + TX + 1;
    init_gap[1] = TS + TE + TH + TX + 1;
    init_gap[2] = TS + TE + TH + TL + 1;

    tv[0] = '{32'h8000_0141, 1'b1, 9'h141, TX};
    tv[1] = '{32'h0000_0002, 1'b0, 9'h002, TL};
    tv[2] = '{32'h8000_0003, 1'b1, 9'h003, TL};
    tv[3] = '{32'h0000_0101, 1'b0, 9'h101, TX};
    tv[4] = '{32'h8000_00FF, 1'b1, 9'h0FF, TX};
    tv[5] = '{32'h7FFF_FE41, 1'b0, 9'h041, TX};

    bus.i_wr   = 1'b0;
    bus.i_word = 32'h0;
    rst = 1'b1;
    tick(); tick(); tick();
    check("rst_data", bus.o_lcd_data, 0);
    check("rst_rs", bus.o_lcd_rs, 0);
    check("rst_rw", bus.o_lcd_rw, 0);
    check("rst_en", bus.o_lcd_en, 0);
    check("rst_on", bus.o_lcd_on, 0);
    check("rst_full", bus.o_full, 0);
    check("rst_ovf", bus.o_overflow, 0);
    check("rst_init_done", bus.o_init_done, 0);
    check("rst_busy", bus.o_busy, 1);
    r = cyc;
    rst = 1'b0;

    wait_pulses(4, 400);
    check("init_first_rise", rise_cyc[0] - r, TP + 1 + TS);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init_byte%0d", i), rise_val[i], {1'b0, init_seq[i]});
      check($sformatf("init_width%0d", i), width[i], TE);
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("init_gap%0d", i),
            rise_cyc[i + 1] - rise_cyc[i], init_gap[i]);
    wait_idle(at);
    check("init_done_time", at - rise_cyc[3], TE + TH + TX);
    check("init_done", bus.o_init_done, 1);
    check("init_rw", bus.o_lcd_rw, 0);

    for (int i = 0; i < 6; i++) begin
      idx = rise_cyc.size();
      wr(tv[i].word);
      w = cyc;
      check($sformatf("v%0d_on", i), bus.o_lcd_on, tv[i].on);
      check($sformatf("v%0d_busy", i), bus.o_busy, 1);
      wait_pulses(idx + 1, 200);
      check($sformatf("v%0d_val", i), rise_val[idx], tv[i].val);
      check($sformatf("v%0d_lat", i), rise_cyc[idx] - w, 1 + TS);
      check($sformatf("v%0d_width", i), width[idx], TE);
      wait_idle(at);
      check($sformatf("v%0d_wait", i), at - rise_cyc[idx],
            TE + TH + tv[i].wt);
    end

    idx = rise_cyc.size();
    wr(32'h0000_0002);
    wr(32'h0000_0141);
    wait_pulses(idx + 2, 300);
    check("b2b_gap", rise_cyc[idx + 1] - rise_cyc[idx],
          TS + TE + TH + TL + 1);
    check("b2b_val", rise_val[idx + 1], 9'h141);
    wait_idle(at);

    idx = rise_cyc.size();
    for (int i = 0; i < 5; i++) wr(32'h0000_0110 + i);
    check("five_full", bus.o_full, 1);
    check("five_ovf", bus.o_overflow, 0);
    wait_pulses(idx + 5, 400);
    for (int i = 0; i < 5; i++)
      check($sformatf("five_val%0d", i), rise_val[idx + i], 9'h110 + i);
    wait_idle(at);
    check("five_count", rise_cyc.size(), idx + 5);
    check("five_ovf_end", bus.o_overflow, 0);
    check("five_full_end", bus.o_full, 0);

    idx = rise_cyc.size();
    for (int i = 0; i < 6; i++) wr(32'h0000_0120 + i);
    check("six_ovf", bus.o_overflow, 1);
    check("six_full", bus.o_full, 1);
    wait_pulses(idx + 5, 400);
    check("six_last", rise_val[idx + 4], 9'h124);
    wait_idle(at);
    check("six_count", rise_cyc.size(), idx + 5);
    check("six_ovf_sticky", bus.o_overflow, 1);

    wr(32'h8000_0177);
    wr(32'h0000_0178);
    wr(32'h0000_0179);
    k = 0;
    while (!bus.o_lcd_en && k < 50) begin
      tick();
      k++;
    end
    check("mid_en_rise", bus.o_lcd_en, 1);
    tick();
    check("mid_en_second", bus.o_lcd_en, 1);
    rst = 1'b1;
    tick();
    check("mid_en_cut", bus.o_lcd_en, 0);
    check("mid_init_done", bus.o_init_done, 0);
    check("mid_busy", bus.o_busy, 1);
    check("mid_full", bus.o_full, 0);
    check("mid_ovf", bus.o_overflow, 0);
    check("mid_on", bus.o_lcd_on, 0);
    r = cyc;
    rst = 1'b0;
    tick();
    base = rise_cyc.size();
    tick(); tick();
    wr(32'h8000_0130);
    check("pwrup_on", bus.o_lcd_on, 1);
    check("pwrup_full", bus.o_full, 0);
    wait_pulses(base + 5, 600);
    check("re_first_rise", rise_cyc[base] - r, TP + 1 + TS);
    check("re_first_val", rise_val[base], 9'h038);
    check("re_held_val", rise_val[base + 4], 9'h130);
    check("re_held_gap", rise_cyc[base + 4] - rise_cyc[base + 3],
          TS + TE + TH + TX + 1);
    check("re_held_width", width[base + 4], TE);
    wait_idle(at);
    check("re_init_done", bus.o_init_done, 1);
    check("re_count", rise_cyc.size(), base + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_driver.md
LCD_HD44780_DRIVER -- requirements
Module: lcd_hd44780_driver

Interface
REQ-001 SHALL have parameter T_SETUP, default 4, meaning cycles from RS/DATA valid to EN rise.
REQ-002 SHALL have parameter T_EN, default 16, meaning EN high width in cycles.
REQ-003 SHALL have parameter T_HOLD, default 4, meaning cycles RS/DATA are held after EN fall.
REQ-004 SHALL have parameter T_EXEC, default 2000, meaning the wait after a normal command/data byte.
REQ-005 SHALL have parameter T_LONG, default 80000, meaning the wait after a clear or home command.
REQ-006 SHALL have parameter T_PWRUP, default 750000, meaning the power-up delay before init.
REQ-007 SHALL have port i_clk, input, 1 bit: the single clock; all logic sits on its rising edge.
REQ-008 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port i_wr, input, 1 bit: one-cycle strobe from the CPU store to the LCD register.
REQ-010 SHALL have port i_word, input, 32 bits: [31] LCD power on, [8] RS, [7:0] byte; other bits ignored.
REQ-011 SHALL have port o_lcd_data, output, 8 bits: HD44780 DB7..DB0.
REQ-012 SHALL have ports o_lcd_rs, o_lcd_rw, o_lcd_en and o_lcd_on, outputs, 1 bit each.
REQ-013 SHALL have port o_busy, output, 1 bit: high during init, while the FIFO is non-empty, or while a transfer/wait is active.
REQ-014 SHALL have ports o_full, o_overflow and o_init_done, outputs, 1 bit each.

Function
REQ-015 SHALL hold o_lcd_rw at 0 at all times (write-only driver).
REQ-016 SHALL latch i_word[31] into o_lcd_on on every i_wr, independent of FIFO state.
REQ-017 SHALL push {i_word[8], i_word[7:0]} into a 4-entry FIFO on i_wr when count<4.
REQ-018 SHALL drop an i_wr that arrives with count==4, even if a pop happens in the same cycle, and set o_overflow (sticky until reset).
REQ-019 SHALL drive o_full = (count==4); pointers SHALL wrap modulo 4.
REQ-020 SHALL use states PWRUP, INIT, IDLE, SETUP, PULSE, HOLD and WAIT.
REQ-021 PWRUP: SHALL count T_PWRUP cycles, then go to INIT.
REQ-022 INIT: SHALL issue the fixed commands 0x38, 0x0C, 0x01, 0x06 (RS=0) in order, each through SETUP->PULSE->HOLD->WAIT, then set o_init_done=1 and go to IDLE.
REQ-023 SHALL accept FIFO writes during PWRUP/INIT; entries are buffered and not popped until IDLE.
REQ-024 IDLE with FIFO non-empty: SHALL pop one entry, drive o_lcd_rs/o_lcd_data from it on the next cycle, and enter SETUP.
REQ-025 SETUP SHALL last exactly T_SETUP cycles with en=0.
REQ-026 PULSE SHALL hold en=1 for exactly T_EN consecutive cycles.
REQ-027 HOLD SHALL last exactly T_HOLD cycles with en=0 and rs/data unchanged.
REQ-028 WAIT SHALL last T_LONG cycles if RS=0 and byte is 0x01, 0x02 or 0x03; otherwise it SHALL last T_EXEC cycles.
REQ-029 After WAIT the block SHALL return to IDLE, or to the next INIT step during init.
REQ-030 o_lcd_rs/o_lcd_data SHALL change only on entry to SETUP.
REQ-031 A single 20-bit down-counter SHALL time all states; no glitches on o_lcd_en.
REQ-032 Back-to-back bytes SHALL be spaced T_SETUP+T_EN+T_HOLD+wait+1 cycles EN-rise to EN-rise.

Reset
REQ-033 On i_reset=1 at a clock edge: state=PWRUP, counter=T_PWRUP, FIFO empty, init step=0.
REQ-034 On reset: o_lcd_data=0, rs=0, rw=0, en=0, on=0, o_full=0, o_overflow=0, o_init_done=0, o_busy=1.
REQ-035 Reset mid-pulse SHALL force o_lcd_en=0 on that same edge and discard the transfer and all FIFO contents.

Verification (bench params: T_SETUP=2, T_EN=3, T_HOLD=2, T_EXEC=10, T_LONG=40, T_PWRUP=20)
REQ-036 Reset release -> 20 cycles idle, then EN pulses carrying 0x38, 0x0C, 0x01, 0x06 with RS=0; 0x01 followed by a 40-cycle wait, the others by 10 cycles; then o_init_done=1 and o_busy=0.
REQ-037 After init, i_wr with i_word=0x8000_0141 -> o_lcd_on=1; rs=1, data=0x41; EN high exactly 3 cycles, starting 2 cycles after data valid; o_busy=1 until the 10-cycle wait ends.
REQ-038 After init, five i_wr strobes on consecutive cycles -> first popped, next four buffered, o_full=1, none dropped, o_overflow=0; six strobes -> sixth dropped and o_overflow=1.
REQ-039 Write 0x002 (home) then 0x141 -> second EN rise exactly 2+3+2+40+1=48 cycles after the first.
REQ-040 Assert i_reset during the second PULSE cycle -> o_lcd_en=0 at that edge, FIFO empty, state PWRUP, o_init_done=0.
REQ-041 Write during PWRUP -> held in FIFO; emitted on the first IDLE after init completes.
